// File: rtl/recovery_lock_ctrl.sv
// recovery_lock_ctrl: sequencer in front of the recovery block. Latches a config snapshot,
// enables recovery, qualifies measured half-rates into a lock, supervises the lock
// (drift, misses, edge timeout, bounded retries) and drains recovery on stop.
module recovery_lock_ctrl #(
    parameter int unsigned COUNTER_WIDTH = 16,
    parameter int unsigned TIMER_WIDTH   = 20,
    parameter int unsigned LOCK_EDGES    = 4,
    parameter int unsigned TOL_SHIFT     = 3,
    parameter int unsigned MISS_LIMIT    = 2,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_en,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [2:0]               mode_i,
    input  logic [COUNTER_WIDTH-1:0] min_hr_i,
    input  logic [COUNTER_WIDTH-1:0] max_hr_i,
    input  logic [TIMER_WIDTH-1:0]   timeout_i,
    input  logic                     rec_busy_i,
    input  logic                     edge_valid_i,
    input  logic [COUNTER_WIDTH-1:0] edge_hr_i,
    input  logic                     pause_i,
    output logic                     rec_en_o,
    output logic [2:0]               rec_mode_o,
    output logic [COUNTER_WIDTH-1:0] rec_min_o,
    output logic [COUNTER_WIDTH-1:0] rec_max_o,
    output logic [COUNTER_WIDTH-1:0] ref_hr_o,
    output logic                     locked_o,
    output logic                     lock_lost_o,
    output logic                     fail_o,
    output logic                     busy_o
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StArm     = 3'd1;
    localparam logic [2:0] StAcquire = 3'd2;
    localparam logic [2:0] StLocked  = 3'd3;
    localparam logic [2:0] StDrain   = 3'd4;
    localparam logic [2:0] StFail    = 3'd5;

    localparam int unsigned GoodW  = $clog2(LOCK_EDGES + 1);
    localparam int unsigned MissW  = $clog2(MISS_LIMIT + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);

    localparam logic [GoodW-1:0]  LockEdgesC  = GoodW'(LOCK_EDGES);
    localparam logic [MissW-1:0]  MissLimitC  = MissW'(MISS_LIMIT);
    localparam logic [RetryW-1:0] MaxRetriesC = RetryW'(MAX_RETRIES);

    logic [2:0]               state_q, state_d;
    logic [2:0]               mode_q, mode_d;
    logic [COUNTER_WIDTH-1:0] min_q, min_d;
    logic [COUNTER_WIDTH-1:0] max_q, max_d;
    logic [COUNTER_WIDTH-1:0] ref_q, ref_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [GoodW-1:0]         good_q, good_d;
    logic [MissW-1:0]         miss_q, miss_d;
    logic [RetryW-1:0]        retry_q, retry_d;
    logic                     rec_en_q, rec_en_d;
    logic                     locked_q, locked_d;
    logic                     lock_lost_q, lock_lost_d;
    logic                     fail_q, fail_d;

    logic                     in_range;
    logic                     in_tol;
    logic [COUNTER_WIDTH-1:0] hr_diff;
    logic [COUNTER_WIDTH:0]   hr_sum;
    logic [COUNTER_WIDTH-1:0] hr_avg;
    logic                     timed_out;
    logic [TIMER_WIDTH-1:0]   timer_inc;
    logic                     lose_lock;

    assign in_range  = (edge_hr_i >= min_q) && (edge_hr_i <= max_q);
    assign hr_diff   = (edge_hr_i > ref_q) ? (edge_hr_i - ref_q) : (ref_q - edge_hr_i);
    // In-tolerance implies in-range: an out-of-range edge never refines the reference.
    assign in_tol    = in_range && (hr_diff <= (ref_q >> TOL_SHIFT));
    assign hr_sum    = {1'b0, ref_q} + {1'b0, edge_hr_i};
    assign hr_avg    = hr_sum[COUNTER_WIDTH:1];
    assign timed_out = (timer_q >= timeout_i);
    assign timer_inc = (&timer_q) ? timer_q : timer_q + 1'b1;

    // Next-state logic: stop first, then timeout, then edge handling.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        min_d       = min_q;
        max_d       = max_q;
        ref_d       = ref_q;
        timer_d     = timer_q;
        good_d      = good_q;
        miss_d      = miss_q;
        retry_d     = retry_q;
        rec_en_d    = rec_en_q;
        locked_d    = locked_q;
        lock_lost_d = 1'b0;
        fail_d      = fail_q;
        lose_lock   = 1'b0;
        if (clk_en) begin
            if (stop_i && (state_q == StArm || state_q == StAcquire || state_q == StLocked)) begin
                state_d  = StDrain;
                rec_en_d = 1'b0;
                locked_d = 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_i) begin
                            mode_d   = mode_i;
                            min_d    = min_hr_i;
                            max_d    = max_hr_i;
                            retry_d  = '0;
                            rec_en_d = 1'b1;
                            state_d  = StArm;
                        end
                    end
                    StArm: begin
                        timer_d = '0;
                        good_d  = '0;
                        miss_d  = '0;
                        state_d = StAcquire;
                    end
                    StAcquire: begin
                        if (timed_out) begin
                            retry_d = retry_q + 1'b1;
                            timer_d = '0;
                            if (retry_d == MaxRetriesC) begin
                                rec_en_d = 1'b0;
                                fail_d   = 1'b1;
                                state_d  = StFail;
                            end else begin
                                state_d = StArm;
                            end
                        end else begin
                            timer_d = timer_inc;
                            if (edge_valid_i) begin
                                if (!in_range) begin
                                    good_d = '0;
                                end else begin
                                    // Any in-range edge counts as accepted and restarts the window.
                                    timer_d = '0;
                                    if (good_q != '0 && in_tol) begin
                                        ref_d  = hr_avg;
                                        good_d = good_q + 1'b1;
                                    end else begin
                                        ref_d  = edge_hr_i;
                                        good_d = GoodW'(1);
                                    end
                                    if (good_d == LockEdgesC) begin
                                        locked_d = 1'b1;
                                        miss_d   = '0;
                                        state_d  = StLocked;
                                    end
                                end
                            end
                        end
                    end
                    StLocked: begin
                        if (timed_out) begin
                            lose_lock = 1'b1;
                        end else begin
                            if (!pause_i) begin
                                timer_d = timer_inc;
                            end
                            if (edge_valid_i) begin
                                if (in_tol) begin
                                    ref_d   = hr_avg;
                                    miss_d  = '0;
                                    timer_d = '0;
                                end else begin
                                    miss_d = miss_q + 1'b1;
                                    if (miss_d == MissLimitC) begin
                                        lose_lock = 1'b1;
                                    end
                                end
                            end
                        end
                        // Fresh timer on loss so reacquisition gets a full window.
                        if (lose_lock) begin
                            lock_lost_d = 1'b1;
                            locked_d    = 1'b0;
                            good_d      = '0;
                            miss_d      = '0;
                            timer_d     = '0;
                            state_d     = StAcquire;
                        end
                    end
                    StDrain: begin
                        if (!rec_busy_i) begin
                            state_d = StIdle;
                        end
                    end
                    StFail: begin
                        if (stop_i) begin
                            fail_d  = 1'b0;
                            state_d = StIdle;
                        end else if (start_i) begin
                            mode_d   = mode_i;
                            min_d    = min_hr_i;
                            max_d    = max_hr_i;
                            retry_d  = '0;
                            fail_d   = 1'b0;
                            rec_en_d = 1'b1;
                            state_d  = StArm;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mode_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            ref_q       <= '0;
            timer_q     <= '0;
            good_q      <= '0;
            miss_q      <= '0;
            retry_q     <= '0;
            rec_en_q    <= 1'b0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            min_q       <= min_d;
            max_q       <= max_d;
            ref_q       <= ref_d;
            timer_q     <= timer_d;
            good_q      <= good_d;
            miss_q      <= miss_d;
            retry_q     <= retry_d;
            rec_en_q    <= rec_en_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            fail_q      <= fail_d;
        end
    end

    assign rec_en_o    = rec_en_q;
    assign rec_mode_o  = mode_q;
    assign rec_min_o   = min_q;
    assign rec_max_o   = max_q;
    assign ref_hr_o    = ref_q;
    assign locked_o    = locked_q;
    assign lock_lost_o = lock_lost_q;
    assign fail_o      = fail_q;
    assign busy_o      = (state_q != StIdle);

endmodule
